ipctrl: RTL and testbench

IPCTRL -- requirements
Module: ipctrl

---
 rtl/ipctrl.sv | 93 +++++++++
 tb/tb_ipctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipctrl.sv
`default_nettype none
// ============================================================================
// Module   : ipctrl
// Brief    : Two-buffer (even/odd VC) router input controller with XY routing.
// Revision : 1.0
// ============================================================================
module ipctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        send_in,
  input  logic [63:0] data_in,
  input  logic        clear_in,
  output logic        ready_even,
  output logic        ready_odd,
  output logic [4:0]  req,
  output logic [63:0] data_out,
  output logic [15:0] rx_count,
  output logic        err
);

  localparam logic [4:0] C_RT_PE = 5'b00001;
  localparam logic [4:0] C_RT_S  = 5'b00010;
  localparam logic [4:0] C_RT_N  = 5'b00100;
  localparam logic [4:0] C_RT_E  = 5'b01000;
  localparam logic [4:0] C_RT_W  = 5'b10000;

  // Index 0 is the even buffer, index 1 the odd buffer.
  logic [1:0]  r_full;
  logic [63:0] r_data  [2];
  logic [4:0]  r_route [2];

  logic [63:0] w_dec_data;
  logic [4:0]  w_dec_route;
  logic        w_clr_sel;
  logic        w_clr_hit;
  logic        w_clr_err;
  logic        w_wr_sel;
  logic        w_wr_ok;
  logic        w_wr_drop;

  always_comb begin
    w_dec_data  = data_in;
    w_dec_route = C_RT_PE;
    if (data_in[55:52] != 4'd0) begin
      w_dec_route        = data_in[62] ? C_RT_W : C_RT_E;
      w_dec_data[55:52]  = data_in[55:52] - 4'd1;
    end else if (data_in[51:48] != 4'd0) begin
      w_dec_route        = data_in[61] ? C_RT_S : C_RT_N;
      w_dec_data[51:48]  = data_in[51:48] - 4'd1;
    end
  end

  // clear_in always refers to the buffer presented in the previous cycle.
  assign w_clr_sel = ~polarity;
  assign w_clr_hit = clear_in & r_full[w_clr_sel];
  assign w_clr_err = clear_in & ~r_full[w_clr_sel];
  assign w_wr_sel  = data_in[63];
  assign w_wr_ok   = send_in & (~r_full[w_wr_sel] | (w_clr_hit & (w_clr_sel == w_wr_sel)));
  assign w_wr_drop = send_in & ~w_wr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full     <= 2'b00;
      r_data[0]  <= 64'h0;
      r_data[1]  <= 64'h0;
      r_route[0] <= 5'b00000;
      r_route[1] <= 5'b00000;
      rx_count   <= 16'h0;
      err        <= 1'b0;
    end else begin
      if (w_clr_hit) begin
        r_full[w_clr_sel] <= 1'b0;
      end
      if (w_wr_ok) begin
        r_full[w_wr_sel]  <= 1'b1;
        r_data[w_wr_sel]  <= w_dec_data;
        r_route[w_wr_sel] <= w_dec_route;
        rx_count          <= rx_count + 16'd1;
      end
      if (w_clr_err | w_wr_drop) begin
        err <= 1'b1;
      end
    end
  end

  assign ready_even = ~r_full[0];
  assign ready_odd  = ~r_full[1];
  assign req        = r_full[polarity] ? r_route[polarity] : 5'b00000;
  assign data_out   = r_full[polarity] ? r_data[polarity]  : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_ipctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipctrl
// Brief    : Self-checking bench for ipctrl against a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_ipctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        polarity = 1'b0;
  logic        send_in = 1'b0;
  logic [63:0] data_in = 64'h0;
  logic        clear_in = 1'b0;
  logic        ready_even, ready_odd, err;
  logic [4:0]  req;
  logic [63:0] data_out;
  logic [15:0] rx_count;

  int total = 0;
  int bad   = 0;
  bit do_check = 1'b1;

  // Reference state: buffer contents as the outside world should see them.
  bit          m_full  [2];
  logic [63:0] m_data  [2];
  logic [4:0]  m_route [2];
  int          m_cnt;
  bit          m_err;

  ipctrl dut (
    .clk(clk), .reset(reset), .polarity(polarity), .send_in(send_in),
    .data_in(data_in), .clear_in(clear_in), .ready_even(ready_even),
    .ready_odd(ready_odd), .req(req), .data_out(data_out),
    .rx_count(rx_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input bit vc, input bit xd, input bit yd,
                                     input int hx, input int hy, input logic [63:0] pay);
    logic [63:0] p;
    p = pay;
    p[63] = vc; p[62] = xd; p[61] = yd;
    p[55:52] = hx[3:0]; p[51:48] = hy[3:0];
    return p;
  endfunction

  task automatic model_step(input bit r, input bit s, input logic [63:0] d, input bit c, input bit p);
    int cb, wb, hx, hy;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 0; m_data[i] = 64'h0; m_route[i] = 5'b0;
      end
      m_cnt = 0; m_err = 0;
      return;
    end
    cb = p ? 0 : 1;
    if (c) begin
      if (m_full[cb]) m_full[cb] = 0;
      else m_err = 1;
    end
    if (s) begin
      wb = d[63] ? 1 : 0;
      if (m_full[wb]) m_err = 1;
      else begin
        hx = int'(d[55:52]); hy = int'(d[51:48]);
        m_data[wb] = d;
        if (hx > 0) begin
          m_route[wb] = d[62] ? 5'd16 : 5'd8;
          m_data[wb][55:52] = 4'(hx - 1);
        end else if (hy > 0) begin
          m_route[wb] = d[61] ? 5'd2 : 5'd4;
          m_data[wb][51:48] = 4'(hy - 1);
        end else begin
          m_route[wb] = 5'd1;
        end
        m_full[wb] = 1;
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
  endtask

  task automatic setin(input bit r, input bit s, input logic [63:0] d, input bit c);
    int pb;
    reset = r; send_in = s; data_in = d; clear_in = c;
    #1;
    if (do_check) begin
      pb = polarity ? 1 : 0;
      chk("ready_even", 64'(ready_even), 64'(!m_full[0]));
      chk("ready_odd",  64'(ready_odd),  64'(!m_full[1]));
      chk("req",        64'(req),        m_full[pb] ? 64'(m_route[pb]) : 64'h0);
      chk("data_out",   data_out,        m_full[pb] ? m_data[pb] : 64'h0);
      chk("rx_count",   64'(rx_count),   64'(m_cnt));
      chk("err",        64'(err),        64'(m_err));
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step(reset, send_in, data_in, clear_in, polarity);
    #1;
    polarity = ~polarity;
  endtask

  task automatic cyc(input bit r, input bit s, input logic [63:0] d, input bit c);
    setin(r, s, d, c);
    edge_step();
  endtask

  task automatic do_reset();
    cyc(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    cyc(1, 0, 64'h0, 0);
  endtask

  initial begin
    logic [63:0] pkt;
    int unsigned rv;

    @(posedge clk); #1;
    do_reset();
    setin(0, 0, 64'h0, 0);
    chk("rst_req", 64'(req), 64'h0);
    chk("rst_ready", 64'({ready_even, ready_odd}), 64'h3);

    // East-bound even packet, two hops.
    cyc(0, 1, mk(0, 0, 0, 2, 0, 64'h1234_5678), 0);
    setin(0, 0, 64'h0, 0);
    chk("east_odd_slot", 64'(req), 64'h0);
    edge_step();
    setin(0, 0, 64'h0, 0);
    chk("east_req", 64'(req), 64'h08);
    chk("east_hx", 64'(data_out[55:52]), 64'h1);
    chk("east_rdy", 64'(ready_even), 64'h0);
    edge_step();

    // Local-delivery odd packet, then freed by clear_in.
    pkt = mk(1, 1, 1, 0, 0, 64'hABCD_EF01_2345);
    cyc(0, 1, pkt, 0);
    cyc(0, 0, 64'h0, 0);
    setin(0, 0, 64'h0, 0);
    chk("pe_req", 64'(req), 64'h01);
    chk("pe_data", data_out, pkt);
    edge_step();
    cyc(0, 0, 64'h0, 1);
    setin(0, 0, 64'h0, 0);
    chk("pe_freed", 64'(ready_odd), 64'h1);
    chk("pe_noreq", 64'(req), 64'h0);
    edge_step();

    // South-bound packet then a drop on the occupied buffer.
    do_reset();
    cyc(0, 1, mk(0, 0, 1, 0, 3, 64'h77), 0);
    cyc(0, 0, 64'h0, 0);
    setin(0, 1, mk(0, 0, 0, 1, 0, 64'h99), 0);
    chk("south_req", 64'(req), 64'h02);
    chk("south_hy", 64'(data_out[51:48]), 64'h2);
    edge_step();
    setin(0, 0, 64'h0, 0);
    chk("drop_err", 64'(err), 64'h1);
    chk("drop_cnt", 64'(rx_count), 64'h1);
    edge_step();

    // Write and clear to the same buffer in one cycle.
    do_reset();
    cyc(0, 1, mk(0, 0, 0, 0, 0, 64'h11), 0);
    pkt = mk(0, 0, 0, 0, 0, 64'h22);
    cyc(0, 1, pkt, 1);
    setin(0, 0, 64'h0, 0);
    chk("wc_data", data_out, pkt);
    chk("wc_err", 64'(err), 64'h0);
    chk("wc_cnt", 64'(rx_count), 64'h2);
    edge_step();

    // Clear with both buffers empty.
    do_reset();
    cyc(0, 0, 64'h0, 1);
    setin(0, 0, 64'h0, 0);
    chk("clr_empty_err", 64'(err), 64'h1);
    chk("clr_empty_rdy", 64'({ready_even, ready_odd}), 64'h3);
    edge_step();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rv  = $urandom;
      pkt = {$urandom, $urandom};
      pkt[55:52] = 4'($urandom_range(0, 3));
      pkt[51:48] = 4'($urandom_range(0, 3));
      cyc((rv % 100) == 0, rv[8], pkt, rv[12:11] == 2'b00);
    end

    // Back-to-back accepted writes up to the counter wrap, then reset.
    do_reset();
    do_check = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      pkt = {$urandom, $urandom};
      pkt[63] = ~polarity;
      cyc(0, 1, pkt, 1);
    end
    do_check = 1'b1;
    setin(0, 0, 64'h0, 0);
    chk("cnt_ffff", 64'(rx_count), 64'hFFFF);
    chk("both_full", 64'({ready_even, ready_odd}), 64'h0);
    pkt[63] = ~polarity;
    setin(0, 1, pkt, 1);
    edge_step();
    setin(0, 0, 64'h0, 0);
    chk("cnt_wrap", 64'(rx_count), 64'h0);
    setin(1, 1, pkt, 1);
    edge_step();
    setin(0, 0, 64'h0, 0);
    chk("post_rst_rdy", 64'({ready_even, ready_odd}), 64'h3);
    chk("post_rst_req", 64'(req), 64'h0);
    chk("post_rst_data", data_out, 64'h0);
    chk("post_rst_err", 64'({err, rx_count}), 64'h0);
    edge_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
